dmem_port_arbiter: RTL and testbench

- Shares the core's single-port synchronous data RAM between instruction fetch (IF) and the load/store unit (LSU).
- Issues at most one access per cycle, with LSU priority and a starvation guard for fetch.
- Routes the 1-cycle-late read data back to the owning requester.
- Read data is returned unregistered in the cycle after issue, so the downstream MEM/WB register does not re-delay it.

---
 rtl/dmem_port_arbiter_pkg.sv | 16 +
 rtl/dmem_starve_guard.sv | 63 ++++++
 rtl/dmem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-RAM port arbiter.
//   - Default address/data widths for the core's data RAM.
//   - Response-tag encoding. The tag records which requester owns the read
//     data that comes back from the RAM one cycle after issue.
package dmem_port_arbiter_pkg;

  localparam int DMEM_ADDR_WIDTH = 32;
  localparam int DMEM_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_LS   = 2'd2
  } rsp_tag_e;

endpackage

// File: rtl/dmem_starve_guard.sv
// Priority decision between fetch and LSU, plus the fetch starvation counter.
// The LSU normally wins. Once it has won STARVE_LIMIT times in a row while
// fetch waits, the next contended cycle goes to fetch.
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   if_valid          fetch request pending
//   ls_valid          LSU request pending
//   grant_if          fetch owns the RAM port this cycle (combinational)
//   grant_ls          LSU owns the RAM port this cycle (combinational)
//   starve_cnt        consecutive LSU grants while fetch waited (registered)
module dmem_starve_guard
  import dmem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       if_valid,
  input  logic       ls_valid,
  output logic       grant_if,
  output logic       grant_ls,
  output logic [3:0] starve_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_next;
  logic       fetch_forced;

  assign fetch_forced = if_valid && (starve_cnt == LIMIT);

  // No grant while in reset, so ready and mem_en stay low.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (!rst) begin
      if (ls_valid && !fetch_forced) begin
        grant_ls = 1'b1;
      end else if (if_valid) begin
        grant_if = 1'b1;
      end
    end
  end

  // Counts only while fetch is actually waiting; saturates at the limit.
  always_comb begin
    starve_cnt_next = starve_cnt;
    if (grant_if || !if_valid) begin
      starve_cnt_next = 4'd0;
    end else if (grant_ls && (starve_cnt != LIMIT)) begin
      starve_cnt_next = 4'(starve_cnt + 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else begin
      starve_cnt <= starve_cnt_next;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port synchronous data RAM between instruction fetch (IF)
// and the load/store unit (LSU). At most one access issues per cycle; the
// read data returning one cycle later is steered to its owner without a
// register, so the MEM/WB stage sees it in the response cycle.
//
// Handshake: a request transfers when valid & ready. Requesters hold valid
// and payload until ready; ready depends only on valid and arbiter state.
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   if_req_*                 fetch request (valid/addr/ready)
//   if_flush                 drop the stale fetch response (taken branch)
//   if_rsp_valid/data        fetch response, cycle after issue
//   ls_req_*                 LSU request (valid/we/be/addr/wdata/ready)
//   ls_rsp_valid/data        load response, cycle after issue
//   mem_*                    RAM port; mem_rdata valid 1 cycle after a read
//   dbg_rsp_tag              current response-tag state
//   dbg_starve_cnt           current fetch starvation count
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = DMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DMEM_DATA_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req_valid,
  input  logic [ADDR_WIDTH-1:0]   if_req_addr,
  output logic                    if_req_ready,
  input  logic                    if_flush,
  output logic                    if_rsp_valid,
  output logic [DATA_WIDTH-1:0]   if_rsp_data,
  input  logic                    ls_req_valid,
  input  logic                    ls_req_we,
  input  logic [DATA_WIDTH/8-1:0] ls_req_be,
  input  logic [ADDR_WIDTH-1:0]   ls_req_addr,
  input  logic [DATA_WIDTH-1:0]   ls_req_wdata,
  output logic                    ls_req_ready,
  output logic                    ls_rsp_valid,
  output logic [DATA_WIDTH-1:0]   ls_rsp_data,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [1:0]              dbg_rsp_tag,
  output logic [3:0]              dbg_starve_cnt
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic     grant_if;
  logic     grant_ls;
  rsp_tag_e rsp_tag;
  rsp_tag_e rsp_tag_next;
  logic     flush_q;
  logic     flush_next;
  logic     if_inflight;

  dmem_starve_guard #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_guard (
    .clk        (clk),
    .rst        (rst),
    .if_valid   (if_req_valid),
    .ls_valid   (ls_req_valid),
    .grant_if   (grant_if),
    .grant_ls   (grant_ls),
    .starve_cnt (dbg_starve_cnt)
  );

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;

  // RAM port mirrors the granted request; idle drives zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_ls) begin
      mem_en    = 1'b1;
      mem_we    = ls_req_we;
      mem_be    = ls_req_be;
      mem_addr  = ls_req_addr;
      mem_wdata = ls_req_wdata;
    end else if (grant_if) begin
      mem_en    = 1'b1;
      mem_be    = {BE_WIDTH{1'b1}};
      mem_addr  = if_req_addr;
    end
  end

  // A fetch response that is still live in this cycle.
  assign if_inflight = (rsp_tag == RSP_IF) && !flush_q;

  // Response-tag FSM: next state is the owner of the read issued this cycle.
  // A flush kills the stale fetch. If a live fetch response is arriving now,
  // that one is stale and the fetch issued alongside the flush is the
  // redirect target, so it is kept. With nothing in flight, the fetch issued
  // alongside the flush is the stale one and its response is marked dead.
  always_comb begin
    rsp_tag_next = RSP_NONE;
    if (grant_ls && !ls_req_we) begin
      rsp_tag_next = RSP_LS;
    end else if (grant_if) begin
      rsp_tag_next = RSP_IF;
    end
    flush_next = grant_if && if_flush && !if_inflight;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_tag <= RSP_NONE;
      flush_q <= 1'b0;
    end else begin
      rsp_tag <= rsp_tag_next;
      flush_q <= flush_next;
    end
  end

  assign dbg_rsp_tag = rsp_tag;

  // Unregistered response steering.
  always_comb begin
    if_rsp_valid = 1'b0;
    ls_rsp_valid = 1'b0;
    if_rsp_data  = '0;
    ls_rsp_data  = '0;
    if (rsp_tag == RSP_IF) begin
      if_rsp_data  = mem_rdata;
      if_rsp_valid = !rst && !if_flush && !flush_q;
    end else if (rsp_tag == RSP_LS) begin
      ls_rsp_data  = mem_rdata;
      ls_rsp_valid = !rst;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter. Inputs change on the falling edge,
// outputs are checked 1 time unit later; the rising edge commits state.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_flush;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        ls_req_valid;
  logic        ls_req_we;
  logic [3:0]  ls_req_be;
  logic [31:0] ls_req_addr;
  logic [31:0] ls_req_wdata;
  logic        ls_req_ready;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_data;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_rsp_tag;
  logic [3:0]  dbg_starve_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ram [0:255];

  // clock/reset block
  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_valid   (if_req_valid),
    .if_req_addr    (if_req_addr),
    .if_req_ready   (if_req_ready),
    .if_flush       (if_flush),
    .if_rsp_valid   (if_rsp_valid),
    .if_rsp_data    (if_rsp_data),
    .ls_req_valid   (ls_req_valid),
    .ls_req_we      (ls_req_we),
    .ls_req_be      (ls_req_be),
    .ls_req_addr    (ls_req_addr),
    .ls_req_wdata   (ls_req_wdata),
    .ls_req_ready   (ls_req_ready),
    .ls_rsp_valid   (ls_rsp_valid),
    .ls_rsp_data    (ls_rsp_data),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_be         (mem_be),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .dbg_rsp_tag    (dbg_rsp_tag),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  // Synchronous single-port RAM model, word indexed by addr[9:2].
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) ram[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= ram[mem_addr[9:2]];
      end
    end
  end

  // driver tasks
  task automatic drv_idle();
    if_req_valid = 1'b0;
    if_req_addr  = '0;
    if_flush     = 1'b0;
    ls_req_valid = 1'b0;
    ls_req_we    = 1'b0;
    ls_req_be    = 4'hf;
    ls_req_addr  = '0;
    ls_req_wdata = '0;
  endtask

  task automatic drv_fetch(input logic [31:0] addr);
    if_req_valid = 1'b1;
    if_req_addr  = addr;
  endtask

  task automatic drv_ls(input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
    ls_req_valid = 1'b1;
    ls_req_we    = we;
    ls_req_be    = be;
    ls_req_addr  = addr;
    ls_req_wdata = wdata;
  endtask

  // Advance to the next falling edge (one rising edge in between).
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[32'h100 >> 2] = 32'hDEAD_BEEF;
    ram[32'h040 >> 2] = 32'h1111_0040;
    ram[32'h080 >> 2] = 32'h2222_0080;
    ram[32'h004 >> 2] = 32'hCAFE_0004;
    ram[32'h020 >> 2] = 32'hAABB_CCDD;
    mem_rdata = 32'h0;

    // Reset, with requests asserted to show they are blocked.
    rst = 1'b1;
    drv_idle();
    next_cycle();
    drv_fetch(32'h100);
    drv_ls(1'b0, 4'hf, 32'h80, 32'h0);
    settle();
    chk("rst_if_ready", {31'b0, if_req_ready}, 32'd0);
    chk("rst_ls_ready", {31'b0, ls_req_ready}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    next_cycle();
    chk("rst_starve", {28'b0, dbg_starve_cnt}, 32'd0);
    chk("rst_tag", {30'b0, dbg_rsp_tag}, 32'd0);
    drv_idle();
    rst = 1'b0;
    settle();
    chk("idle_mem_en", {31'b0, mem_en}, 32'd0);
    chk("idle_mem_addr", mem_addr, 32'd0);
    chk("idle_mem_be", {28'b0, mem_be}, 32'd0);
    chk("post_rst_if_rsp", {31'b0, if_rsp_valid}, 32'd0);

    // Single fetch to 0x100.
    next_cycle();
    drv_fetch(32'h100);
    settle();
    chk("f1_if_ready", {31'b0, if_req_ready}, 32'd1);
    chk("f1_mem_en", {31'b0, mem_en}, 32'd1);
    chk("f1_mem_we", {31'b0, mem_we}, 32'd0);
    chk("f1_mem_be", {28'b0, mem_be}, 32'hf);
    chk("f1_mem_addr", mem_addr, 32'h100);
    next_cycle();
    drv_idle();
    settle();
    chk("f1_if_rsp_valid", {31'b0, if_rsp_valid}, 32'd1);
    chk("f1_if_rsp_data", if_rsp_data, 32'hDEAD_BEEF);
    chk("f1_ls_rsp_valid", {31'b0, ls_rsp_valid}, 32'd0);
    chk("f1_ls_rsp_data", ls_rsp_data, 32'd0);

    // Simultaneous fetch 0x40 and load 0x80.
    next_cycle();
    drv_fetch(32'h40);
    drv_ls(1'b0, 4'hf, 32'h80, 32'h0);
    settle();
    chk("c_ls_ready", {31'b0, ls_req_ready}, 32'd1);
    chk("c_if_ready0", {31'b0, if_req_ready}, 32'd0);
    chk("c_mem_addr0", mem_addr, 32'h80);
    next_cycle();
    ls_req_valid = 1'b0;
    settle();
    chk("c_ls_rsp_valid", {31'b0, ls_rsp_valid}, 32'd1);
    chk("c_ls_rsp_data", ls_rsp_data, 32'h2222_0080);
    chk("c_if_ready1", {31'b0, if_req_ready}, 32'd1);
    chk("c_mem_addr1", mem_addr, 32'h40);
    next_cycle();
    drv_idle();
    settle();
    chk("c_if_rsp_valid", {31'b0, if_rsp_valid}, 32'd1);
    chk("c_if_rsp_data", if_rsp_data, 32'h1111_0040);
    chk("c_ls_rsp_valid2", {31'b0, ls_rsp_valid}, 32'd0);

    // Starvation guard: LSU held for 10 cycles with fetch pending, limit 4.
    // Expected: IF wins cycles 4 and 9; the count cycles 0,1,2,3,4,0,...
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      drv_fetch(32'h4);
      drv_ls(1'b0, 4'hf, 32'h0, 32'h0);
      settle();
      chk($sformatf("s%0d_if_ready", i), {31'b0, if_req_ready},
          (i == 4 || i == 9) ? 32'd1 : 32'd0);
      chk($sformatf("s%0d_ls_ready", i), {31'b0, ls_req_ready},
          (i == 4 || i == 9) ? 32'd0 : 32'd1);
      chk($sformatf("s%0d_starve", i), {28'b0, dbg_starve_cnt}, 32'(i % 5));
    end
    next_cycle();
    drv_idle();
    settle();
    chk("s_if_rsp_valid", {31'b0, if_rsp_valid}, 32'd1);
    chk("s_if_rsp_data", if_rsp_data, 32'hCAFE_0004);

    // Store then load of the same word.
    next_cycle();
    drv_ls(1'b1, 4'b0011, 32'h20, 32'h0000_1234);
    settle();
    chk("st_ls_ready", {31'b0, ls_req_ready}, 32'd1);
    chk("st_mem_we", {31'b0, mem_we}, 32'd1);
    chk("st_mem_be", {28'b0, mem_be}, 32'h3);
    chk("st_mem_addr", mem_addr, 32'h20);
    chk("st_mem_wdata", mem_wdata, 32'h0000_1234);
    next_cycle();
    drv_ls(1'b0, 4'hf, 32'h20, 32'h0);
    settle();
    chk("st_no_rsp", {31'b0, ls_rsp_valid}, 32'd0);
    chk("st_tag_none", {30'b0, dbg_rsp_tag}, 32'd0);
    chk("ld_mem_we", {31'b0, mem_we}, 32'd0);
    next_cycle();
    drv_idle();
    settle();
    chk("ld_rsp_valid", {31'b0, ls_rsp_valid}, 32'd1);
    chk("ld_rsp_data", ls_rsp_data, 32'hAABB_1234);

    // Flush: fetch in cycle 0, flush plus redirect fetch in cycle 1.
    next_cycle();
    drv_fetch(32'h100);
    settle();
    chk("fl_if_ready0", {31'b0, if_req_ready}, 32'd1);
    next_cycle();
    drv_fetch(32'h40);
    if_flush = 1'b1;
    settle();
    chk("fl_rsp_killed", {31'b0, if_rsp_valid}, 32'd0);
    chk("fl_if_ready1", {31'b0, if_req_ready}, 32'd1);
    next_cycle();
    drv_idle();
    settle();
    chk("fl_redirect_valid", {31'b0, if_rsp_valid}, 32'd1);
    chk("fl_redirect_data", if_rsp_data, 32'h1111_0040);
    // Flush in the same cycle as a fetch with nothing in flight.
    next_cycle();
    drv_fetch(32'h100);
    if_flush = 1'b1;
    settle();
    next_cycle();
    drv_idle();
    settle();
    chk("fl_same_cycle_tag", {30'b0, dbg_rsp_tag}, 32'd1);
    chk("fl_same_cycle_killed", {31'b0, if_rsp_valid}, 32'd0);

    // Load in flight when reset asserts; starve count built up first.
    next_cycle();
    drv_fetch(32'h4);
    drv_ls(1'b0, 4'hf, 32'h80, 32'h0);
    settle();
    chk("rl_ls_ready", {31'b0, ls_req_ready}, 32'd1);
    next_cycle();
    rst = 1'b1;
    settle();
    chk("rl_starve_pre", {28'b0, dbg_starve_cnt}, 32'd1);
    chk("rl_rsp_in_rst", {31'b0, ls_rsp_valid}, 32'd0);
    chk("rl_ls_ready_rst", {31'b0, ls_req_ready}, 32'd0);
    chk("rl_mem_en_rst", {31'b0, mem_en}, 32'd0);
    next_cycle();
    settle();
    chk("rl_rsp_in_rst2", {31'b0, ls_rsp_valid}, 32'd0);
    next_cycle();
    rst = 1'b0;
    drv_idle();
    settle();
    chk("rl_ls_rsp_after", {31'b0, ls_rsp_valid}, 32'd0);
    chk("rl_if_rsp_after", {31'b0, if_rsp_valid}, 32'd0);
    chk("rl_starve_after", {28'b0, dbg_starve_cnt}, 32'd0);

    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
